// File: rtl/alu_flags_unit.sv
// C/Z/I architectural flag register with a nestable {C,Z} shadow stack for interrupts.
// Optional sticky stack-misuse flag enabled by defining FLG_SHAD_ERR_EN.
module alu_flags_unit #(
    parameter int unsigned SHAD_DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(SHAD_DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             C_IN,
    input  logic             Z_IN,
    input  logic             FLG_C_LD,
    input  logic             FLG_Z_LD,
    input  logic             FLG_C_SET,
    input  logic             FLG_C_CLR,
    input  logic             I_SET,
    input  logic             I_CLR,
    input  logic             SHAD_PUSH,
    input  logic             SHAD_POP,
    output logic             C_FLAG,
    output logic             Z_FLAG,
    output logic             I_FLAG,
    output logic [CNT_W-1:0] SHAD_CNT,
    output logic             SHAD_FULL,
    output logic             SHAD_EMPTY,
    output logic             SHAD_ERR
);

    // Sized to the full index range so SHAD_CNT indexes it without truncation.
    localparam int unsigned STK_N = 1 << CNT_W;

    logic             r_c;
    logic             r_z;
    logic             r_i;
    logic [CNT_W-1:0] r_shad_cnt;
    logic [1:0]       r_stack [STK_N];

    logic             w_full;
    logic             w_empty;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic [CNT_W-1:0] w_top_idx;
    logic [1:0]       w_top;
    logic             w_c_d;
    logic             w_z_d;
    logic             w_i_d;
    logic [CNT_W-1:0] w_cnt_d;

    assign w_full    = (r_shad_cnt == CNT_W'(SHAD_DEPTH));
    assign w_empty   = (r_shad_cnt == '0);
    assign w_push_ok = SHAD_PUSH & ~SHAD_POP & ~w_full;
    assign w_pop_ok  = SHAD_POP & ~SHAD_PUSH & ~w_empty;
    assign w_top_idx = r_shad_cnt - CNT_W'(1);
    assign w_top     = r_stack[w_top_idx];

    always_comb begin
        w_c_d   = r_c;
        w_z_d   = r_z;
        w_i_d   = r_i;
        w_cnt_d = r_shad_cnt;

        if (w_pop_ok) begin
            w_c_d = w_top[1];
        end else if (FLG_C_SET) begin
            w_c_d = 1'b1;
        end else if (FLG_C_CLR) begin
            w_c_d = 1'b0;
        end else if (FLG_C_LD) begin
            w_c_d = C_IN;
        end

        if (w_pop_ok) begin
            w_z_d = w_top[0];
        end else if (FLG_Z_LD) begin
            w_z_d = Z_IN;
        end

        // Interrupt entry masks further interrupts even if the push itself is rejected.
        if (SHAD_PUSH) begin
            w_i_d = 1'b0;
        end else if (I_SET) begin
            w_i_d = 1'b1;
        end else if (I_CLR) begin
            w_i_d = 1'b0;
        end

        if (w_push_ok) begin
            w_cnt_d = r_shad_cnt + CNT_W'(1);
        end else if (w_pop_ok) begin
            w_cnt_d = r_shad_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_c        <= 1'b0;
            r_z        <= 1'b0;
            r_i        <= 1'b0;
            r_shad_cnt <= '0;
        end else begin
            r_c        <= w_c_d;
            r_z        <= w_z_d;
            r_i        <= w_i_d;
            r_shad_cnt <= w_cnt_d;
        end
    end

    // Stack storage needs no reset; SHAD_CNT alone defines which entries are valid.
    always_ff @(posedge CLK) begin
        if (!RST && w_push_ok) begin
            r_stack[r_shad_cnt] <= {r_c, r_z};
        end
    end

`ifdef FLG_SHAD_ERR_EN
    logic w_err_evt;
    logic r_err;

    assign w_err_evt = (SHAD_PUSH & SHAD_POP) | (SHAD_PUSH & w_full) | (SHAD_POP & w_empty);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_err <= 1'b0;
        end else if (w_err_evt) begin
            r_err <= 1'b1;
        end
    end

    assign SHAD_ERR = r_err;
`else
    assign SHAD_ERR = 1'b0;
`endif

    assign C_FLAG     = r_c;
    assign Z_FLAG     = r_z;
    assign I_FLAG     = r_i;
    assign SHAD_CNT   = r_shad_cnt;
    assign SHAD_FULL  = w_full;
    assign SHAD_EMPTY = w_empty;

endmodule

// File: tb/tb_alu_flags_unit.sv
// Table-driven bench for alu_flags_unit with a scoreboard queue of expected flag states.
module tb_alu_flags_unit;

`ifdef FLG_SHAD_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       c_in, z_in, c_ld, z_ld, c_set, c_clr, i_set, i_clr, push, pop;
    logic       c_flag, z_flag, i_flag, shad_full, shad_empty, shad_err;
    logic [1:0] shad_cnt;

    alu_flags_unit #(.SHAD_DEPTH(2)) u_dut (
        .CLK        (clk),
        .RST        (rst),
        .C_IN       (c_in),
        .Z_IN       (z_in),
        .FLG_C_LD   (c_ld),
        .FLG_Z_LD   (z_ld),
        .FLG_C_SET  (c_set),
        .FLG_C_CLR  (c_clr),
        .I_SET      (i_set),
        .I_CLR      (i_clr),
        .SHAD_PUSH  (push),
        .SHAD_POP   (pop),
        .C_FLAG     (c_flag),
        .Z_FLAG     (z_flag),
        .I_FLAG     (i_flag),
        .SHAD_CNT   (shad_cnt),
        .SHAD_FULL  (shad_full),
        .SHAD_EMPTY (shad_empty),
        .SHAD_ERR   (shad_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // in  = {rst, c_in, z_in, c_ld, z_ld, c_set, c_clr, i_set, i_clr, push, pop}
    // exp = {c, z, i, cnt[1:0], err-if-enabled}
    typedef struct {
        string       name;
        logic [10:0] in;
        logic [5:0]  exp;
    } vec_t;

    typedef struct {
        string      name;
        logic       c, z, i, full, empty, err;
        logic [1:0] cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        {rst, c_in, z_in, c_ld, z_ld, c_set, c_clr, i_set, i_clr, push, pop} = v.in;
        e.name  = v.name;
        e.c     = v.exp[5];
        e.z     = v.exp[4];
        e.i     = v.exp[3];
        e.cnt   = v.exp[2:1];
        e.err   = v.exp[0] & ErrEn;
        e.full  = (v.exp[2:1] == 2'd2);
        e.empty = (v.exp[2:1] == 2'd0);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty", v.name);
        end else begin
            e = sb.pop_front();
            check({e.name, ".c"},     {7'd0, c_flag},     {7'd0, e.c});
            check({e.name, ".z"},     {7'd0, z_flag},     {7'd0, e.z});
            check({e.name, ".i"},     {7'd0, i_flag},     {7'd0, e.i});
            check({e.name, ".cnt"},   {6'd0, shad_cnt},   {6'd0, e.cnt});
            check({e.name, ".full"},  {7'd0, shad_full},  {7'd0, e.full});
            check({e.name, ".empty"}, {7'd0, shad_empty}, {7'd0, e.empty});
            check({e.name, ".err"},   {7'd0, shad_err},   {7'd0, e.err});
        end
    endtask

    initial begin
        {rst, c_in, z_in, c_ld, z_ld, c_set, c_clr, i_set, i_clr, push, pop} = '0;
        vecs = '{
            '{"rst_all_hi",    11'b1_1_1_1_1_1_1_1_1_1_1, 6'b0_0_0_00_0},
            '{"ld_cz",         11'b0_1_1_1_1_0_0_0_0_0_0, 6'b1_1_0_00_0},
            '{"set_clr_ld",    11'b0_0_0_1_0_1_1_0_0_0_0, 6'b1_1_0_00_0},
            '{"z0_iset",       11'b0_0_0_0_1_0_0_1_0_0_0, 6'b1_0_1_00_0},
            '{"push1",         11'b0_0_0_0_0_0_0_0_0_1_0, 6'b1_0_0_01_0},
            '{"ld_c0_z1",      11'b0_0_1_1_1_0_0_0_0_0_0, 6'b0_1_0_01_0},
            '{"pop_iset",      11'b0_0_0_0_0_0_0_1_0_0_1, 6'b1_0_1_00_0},
            '{"push_10_strb",  11'b0_0_1_0_1_0_1_0_0_1_0, 6'b0_1_0_01_0},
            '{"push_01",       11'b0_0_0_0_0_0_0_0_0_1_0, 6'b0_1_0_10_0},
            '{"push_ovf",      11'b0_0_0_0_0_1_0_1_0_1_0, 6'b1_1_0_10_1},
            '{"pop_01",        11'b0_0_0_0_0_0_0_0_0_0_1, 6'b0_1_0_01_1},
            '{"pop_10",        11'b0_0_0_0_0_0_0_0_0_0_1, 6'b1_0_0_00_1},
            '{"rst_err",       11'b1_0_0_0_0_0_0_0_0_0_0, 6'b0_0_0_00_0},
            '{"pop_empty_zld", 11'b0_0_1_0_1_1_0_0_0_0_1, 6'b1_1_0_00_1},
            '{"rst_clear_err", 11'b1_0_0_0_0_0_0_0_0_0_0, 6'b0_0_0_00_0},
            '{"iset",          11'b0_0_0_0_0_0_0_1_0_0_0, 6'b0_0_1_00_0},
            '{"push_cset",     11'b0_0_0_0_0_1_0_0_0_1_0, 6'b1_0_0_01_0},
            '{"push_pop_both", 11'b0_0_1_0_1_0_0_1_0_1_1, 6'b1_1_0_01_1},
            '{"iset_iclr",     11'b0_0_0_0_0_0_0_1_1_0_0, 6'b1_1_1_01_1},
            '{"iclr",          11'b0_0_0_0_0_0_0_0_1_0_0, 6'b1_1_0_01_1},
            '{"pop_over_strb", 11'b0_0_1_0_1_0_1_0_0_0_1, 6'b0_0_0_00_1},
            '{"nest_push1",    11'b0_0_0_0_0_0_0_0_0_1_0, 6'b0_0_0_01_1},
            '{"nest_push2",    11'b0_0_0_0_0_0_0_0_0_1_0, 6'b0_0_0_10_1},
            '{"rst_mid_nest",  11'b1_0_0_0_0_1_0_0_0_1_0, 6'b0_0_0_00_0},
            '{"pop_after_rst", 11'b0_0_0_0_0_0_0_0_0_0_1, 6'b0_0_0_00_1},
            '{"cset",          11'b0_0_0_0_0_1_0_0_0_0_0, 6'b1_0_0_00_1},
            '{"clr_over_ld",   11'b0_1_0_1_0_0_1_0_0_0_0, 6'b0_0_0_00_1}
        };
        foreach (vecs[k]) apply(vecs[k]);

        // Hand sequence: fill with distinct entries, idle, then drain in LIFO order.
        apply('{"h_rst",     11'b1_0_0_0_0_0_0_0_0_0_0, 6'b0_0_0_00_0});
        apply('{"h_ld_c1",   11'b0_1_0_1_0_0_0_0_0_0_0, 6'b1_0_0_00_0});
        apply('{"h_push_10", 11'b0_0_1_0_1_0_1_0_0_1_0, 6'b0_1_0_01_0});
        apply('{"h_push_01", 11'b0_0_0_0_0_1_0_0_0_1_0, 6'b1_1_0_10_0});
        for (int n = 0; n < 3; n++) begin
            apply('{"h_hold",    11'b0_0_0_0_0_0_0_0_0_0_0, 6'b1_1_0_10_0});
        end
        apply('{"h_pop_01",  11'b0_0_0_0_0_0_0_0_0_0_1, 6'b0_1_0_01_0});
        apply('{"h_pop_10",  11'b0_0_0_0_0_0_0_0_0_0_1, 6'b1_0_0_00_0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
